// File: rtl/adder_arbiter_if.sv
// Request, shared-adder and response signals of the adder arbiter.
// The slave modport is the arbiter side; master is the requester/consumer/adder side.
interface adder_arbiter_if #(
    parameter int WIDTH    = 32,
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_operand_a;
    logic [NUM_REQ*WIDTH-1:0] req_operand_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         adder_operand_a;
    logic [WIDTH-1:0]         adder_operand_b;
    logic [WIDTH-1:0]         adder_result;
    logic                     resp_valid;
    logic [ID_WIDTH-1:0]      resp_id;
    logic [WIDTH-1:0]         resp_result;
    logic                     resp_ready;

    modport slave (
        input  req_valid, req_operand_a, req_operand_b, adder_result, resp_ready,
        output req_ready, adder_operand_a, adder_operand_b, resp_valid, resp_id, resp_result
    );

    modport master (
        output req_valid, req_operand_a, req_operand_b, adder_result, resp_ready,
        input  req_ready, adder_operand_a, adder_operand_b, resp_valid, resp_id, resp_result
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one combinational adder among NUM_REQ requesters.
// The winning sum is captured in a single registered response slot tagged with
// the requester id and held until the consumer accepts it.
module adder_arbiter #(
    parameter int WIDTH    = 32,
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    adder_arbiter_if.slave bus
);
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic                resp_valid_q, resp_valid_d;
    logic [ID_WIDTH-1:0] resp_id_q, resp_id_d;
    logic [WIDTH-1:0]    resp_result_q, resp_result_d;

    logic                can_accept;
    logic                found;
    logic                grant;
    logic [ID_WIDTH-1:0] winner;
    logic [ID_WIDTH:0]   scan;
    logic [NUM_REQ-1:0]  ready;
    logic [WIDTH-1:0]    opa, opb;

    // A slot being drained this cycle can take a new result; an empty slot never looks at resp_ready.
    assign can_accept = !resp_valid_q || bus.resp_ready;
    assign grant      = found && can_accept && !reset;

    // Scan req_valid from ptr upward, wrapping, and pick the first set bit.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        scan   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
            if (scan >= (ID_WIDTH+1)'(NUM_REQ)) begin
                scan = scan - (ID_WIDTH+1)'(NUM_REQ);
            end
            if (!found && bus.req_valid[scan[ID_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = scan[ID_WIDTH-1:0];
            end
        end
    end

    // One-hot grant and adder operand steering; operands are zero when idle.
    always_comb begin
        ready = '0;
        opa   = '0;
        opb   = '0;
        if (grant) begin
            ready[winner] = 1'b1;
            opa           = bus.req_operand_a[winner*WIDTH +: WIDTH];
            opb           = bus.req_operand_b[winner*WIDTH +: WIDTH];
        end
    end

    assign bus.req_ready       = ready;
    assign bus.adder_operand_a = opa;
    assign bus.adder_operand_b = opb;

    // Slot and pointer next state: a grant loads the slot, an accept alone empties it.
    always_comb begin
        ptr_d         = ptr_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        if (grant) begin
            resp_result_d = bus.adder_result;
            resp_id_d     = winner;
            resp_valid_d  = 1'b1;
            ptr_d         = (winner == ID_WIDTH'(NUM_REQ-1)) ? '0 : winner + ID_WIDTH'(1);
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending response and restarts the scan at 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
        end else begin
            ptr_q         <= ptr_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: stimulus pushes hand-computed responses into
// a queue, a negedge monitor pops and compares each accepted response.
module tb_adder_arbiter;
    localparam int WIDTH    = 32;
    localparam int NUM_REQ  = 4;
    localparam int ID_WIDTH = 2;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [WIDTH-1:0]    res;
    } exp_t;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       rv;
    logic                     rr;
    logic [NUM_REQ*WIDTH-1:0] opa;
    logic [NUM_REQ*WIDTH-1:0] opb;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;

    adder_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) bus ();

    adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Shared combinational adder model
    assign bus.adder_result  = bus.adder_operand_a + bus.adder_operand_b;
    assign bus.req_valid     = rv;
    assign bus.resp_ready    = rr;
    assign bus.req_operand_a = opa;
    assign bus.req_operand_b = opb;

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        opa[i*WIDTH +: WIDTH] = a;
        opb[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic push(input int id, input logic [WIDTH-1:0] res);
        exp_t e;
        e.id  = ID_WIDTH'(id);
        e.res = res;
        sb.push_back(e);
    endtask

    // Monitor: every response the consumer accepts must match the head of the queue
    always @(negedge clock) begin
        if (!reset && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL resp_unexpected: got id %0d result 0x%0h, want no response",
                         bus.resp_id, bus.resp_result);
            end else begin
                mon_e = sb.pop_front();
                check("mon_resp_id", 64'(bus.resp_id), 64'(mon_e.id));
                check("mon_resp_result", 64'(bus.resp_result), 64'(mon_e.res));
            end
        end
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rv    = '0;
        rr    = 1'b0;
        opa   = '0;
        opb   = '0;

        // Reset state with a request present
        rv = 4'b0001;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 0);
        check("rst_resp_valid", 64'(bus.resp_valid), 0);
        check("rst_resp_result", 64'(bus.resp_result), 0);
        check("rst_resp_id", 64'(bus.resp_id), 0);

        // Round-robin fairness from ptr=0
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, WIDTH'(32'h100 * i), WIDTH'(i));
        reset = 1'b0;
        rv    = 4'b1111;
        rr    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_req_ready", 64'(bus.req_ready), 64'(1 << (k % 4)));
            push(k % 4, WIDTH'(32'h101 * (k % 4)));
            tick();
        end

        // Idle drive: operands zero, no grant, pending response drains
        rv = '0;
        #1;
        check("idle_opa", 64'(bus.adder_operand_a), 0);
        check("idle_opb", 64'(bus.adder_operand_b), 0);
        check("idle_req_ready", 64'(bus.req_ready), 0);
        tick();
        check("idle_drained", 64'(bus.resp_valid), 0);

        // Single request from requester 2 (ptr=1)
        set_ops(2, 5, 7);
        rv = 4'b0100;
        #1;
        check("single_req_ready", 64'(bus.req_ready), 4);
        check("single_opa", 64'(bus.adder_operand_a), 5);
        push(2, 12);
        tick();
        rv = '0;
        #1;
        check("single_resp_valid", 64'(bus.resp_valid), 1);
        check("single_resp_result", 64'(bus.resp_result), 12);
        check("single_resp_id", 64'(bus.resp_id), 2);
        tick();

        // Backpressure: fill slot with id 1 / 0x20, grant happens even with resp_ready low
        rr = 1'b0;
        set_ops(1, 32'h10, 32'h10);
        rv = 4'b0010;
        #1;
        check("bp_fill_ready", 64'(bus.req_ready), 2);
        push(1, 32'h20);
        tick();
        set_ops(2, 32'h30, 32'h3);
        rv = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_req_ready", 64'(bus.req_ready), 0);
            check("bp_resp_valid", 64'(bus.resp_valid), 1);
            check("bp_resp_id", 64'(bus.resp_id), 1);
            check("bp_resp_result", 64'(bus.resp_result), 32'h20);
            tick();
        end
        rr = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.req_ready), 4);
        push(2, 32'h33);
        tick();
        rv = '0;
        #1;
        check("bp_replace_id", 64'(bus.resp_id), 2);
        check("bp_replace_result", 64'(bus.resp_result), 32'h33);
        tick();

        // Wrap arithmetic (ptr=3)
        set_ops(3, 32'hFFFF_FFFF, 32'h0000_0001);
        rv = 4'b1000;
        #1;
        check("wrap1_ready", 64'(bus.req_ready), 8);
        push(3, 32'h0);
        tick();
        set_ops(0, 32'h8000_0000, 32'h8000_0000);
        rv = 4'b0001;
        #1;
        check("wrap2_ready", 64'(bus.req_ready), 1);
        push(0, 32'h0);
        tick();
        rv = '0;
        #1;
        check("wrap_idle_opa", 64'(bus.adder_operand_a), 0);
        check("wrap_idle_ready", 64'(bus.req_ready), 0);
        tick();
        check("wrap_drained", 64'(bus.resp_valid), 0);

        // Reset mid-stream with slot holding 0x10 (ptr=1 -> grant 1, ptr becomes 2)
        rr = 1'b0;
        set_ops(1, 32'h8, 32'h8);
        rv = 4'b0010;
        #1;
        check("mid_fill_ready", 64'(bus.req_ready), 2);
        tick();
        rv = '0;
        #1;
        check("mid_full_valid", 64'(bus.resp_valid), 1);
        check("mid_full_result", 64'(bus.resp_result), 32'h10);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.resp_valid), 0);
        check("mid_rst_result", 64'(bus.resp_result), 0);
        check("mid_rst_id", 64'(bus.resp_id), 0);
        rv = 4'b1111;
        #1;
        check("mid_rst_req_ready", 64'(bus.req_ready), 0);
        set_ops(0, 3, 4);
        tick();
        reset = 1'b0;
        rr    = 1'b1;
        #1;
        check("post_rst_ready", 64'(bus.req_ready), 1);
        push(0, 7);
        tick();
        rv = '0;
        #1;
        check("post_rst_id", 64'(bus.resp_id), 0);
        check("post_rst_result", 64'(bus.resp_result), 7);
        tick();
        tick();
        check("sb_empty", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
